// File: rtl/comparator_cal_pkg.sv
// Shared types and helpers for the comparator array with SAR offset calibration.
// Analog quantities are carried as signed 32-bit microvolt samples.
package comparator_cal_pkg;

    localparam int VW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } cal_state_e;

    // Trim correction for an offset-binary code, in the same microvolt units as lsb_uv.
    function automatic int trim_to_volts(input int code, input int lsb_uv, input int trim_w);
        return (code - (1 << (trim_w - 1))) * lsb_uv;
    endfunction

    function automatic logic vote_ok(input int ones, input int nvote);
        return (2 * ones) >= nvote;
    endfunction

    function automatic int volts_to_uv(input real v);
        return int'(v * 1.0e6);
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// One comparator channel: offset and trim correction, hysteresis and the decision register.
// Also reports the shorted-input decision for a given trial code during calibration.
module comparator_slice
    import comparator_cal_pkg::*;
#(
    parameter int TRIM_W       = 6,
    parameter int LSB_UV       = 1000,
    parameter int HALF_HYST_UV = 0,
    parameter int OFF_UV       = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hold,
    input  logic              vdd_ok,
    input  logic [VW-1:0]     inp,
    input  logic [VW-1:0]     inn,
    input  logic [TRIM_W-1:0] trim,
    input  logic [TRIM_W-1:0] cal_code,
    output logic              cal_bit,
    output logic              out
);

    localparam logic signed [VW+1:0] OFF     = (VW+2)'(OFF_UV);
    localparam logic signed [VW+1:0] HYST_HI = (VW+2)'(HALF_HYST_UV);
    localparam logic signed [VW+1:0] HYST_LO = -HYST_HI;

    logic signed [VW+1:0] diff;
    logic signed [VW+1:0] trim_v;
    logic signed [VW+1:0] cal_v;
    logic signed [VW+1:0] d_norm;
    logic signed [VW+1:0] d_cal;
    logic                 out_q;
    logic                 out_d;

    always_comb begin
        diff    = (VW+2)'($signed(inp)) - (VW+2)'($signed(inn));
        trim_v  = (VW+2)'(trim_to_volts(int'(trim), LSB_UV, TRIM_W));
        cal_v   = (VW+2)'(trim_to_volts(int'(cal_code), LSB_UV, TRIM_W));
        d_norm  = diff + OFF - trim_v;
        d_cal   = OFF - cal_v;
        cal_bit = !d_cal[VW+1];
        // The current decision selects which edge of the hysteresis window applies.
        if (hold || !vdd_ok) begin
            out_d = 1'b0;
        end else if (out_q) begin
            out_d = (d_norm >= HYST_LO);
        end else begin
            out_d = (d_norm >= HYST_HI);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/comparator_cal_array.sv
// NCH-channel clocked comparator array with a trim register file and a shared
// SAR engine that finds each channel's offset trim by majority-voted trials.
module comparator_cal_array
    import comparator_cal_pkg::*;
#(
    parameter int  NCH         = 4,
    parameter int  TRIM_W      = 6,
    parameter real LSB         = 1.0e-3,
    parameter int  NVOTE       = 3,
    parameter real HYST        = 0.0,
    parameter real OFFSET0     = 0.0,
    parameter real OFFSET_STEP = 0.0,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [VW-1:0]     vdd,
    input  logic [NCH*VW-1:0] inp,
    input  logic [NCH*VW-1:0] inn,
    input  logic              cal_start,
    input  logic              trim_wr,
    input  logic [CH_W-1:0]   trim_ch,
    input  logic [TRIM_W-1:0] trim_wdata,
    output logic [TRIM_W-1:0] trim_rdata,
    output logic [NCH-1:0]    out,
    output logic              cal_busy,
    output logic              cal_done
);

    localparam int BIT_W        = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int VOTE_W       = $clog2(NVOTE + 1);
    localparam int LSB_UV       = volts_to_uv(LSB);
    localparam int HALF_HYST_UV = volts_to_uv(HYST / 2.0);
    localparam logic [TRIM_W-1:0] MID_CODE = {1'b1, {(TRIM_W-1){1'b0}}};

    cal_state_e        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [TRIM_W-1:0] code_q, code_d;
    logic [VOTE_W-1:0] vote_q, vote_d;
    logic [VOTE_W-1:0] ones_q, ones_d;
    logic [TRIM_W-1:0] trim_q [NCH];
    logic [TRIM_W-1:0] trim_d [NCH];
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [NCH-1:0]    cal_bit;
    logic [VOTE_W-1:0] ones_next;
    logic [TRIM_W-1:0] code_res;
    logic              vdd_ok;

    assign vdd_ok = ($signed(vdd) >= 32'sd500000);

    for (genvar g = 0; g < NCH; g++) begin : g_slice
        localparam int OFF_UV = volts_to_uv(OFFSET0 + real'(g) * OFFSET_STEP);
        comparator_slice #(
            .TRIM_W      (TRIM_W),
            .LSB_UV      (LSB_UV),
            .HALF_HYST_UV(HALF_HYST_UV),
            .OFF_UV      (OFF_UV)
        ) u_slice (
            .clk     (clk),
            .rstn    (rstn),
            .hold    (state_q != IDLE),
            .vdd_ok  (vdd_ok),
            .inp     (inp[g*VW +: VW]),
            .inn     (inn[g*VW +: VW]),
            .trim    (trim_q[g]),
            .cal_code(code_q),
            .cal_bit (cal_bit[g]),
            .out     (out[g])
        );
    end

    // SAR sequencing: NVOTE votes per bit, TRIM_W bits per channel, channels in order.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        bit_d     = bit_q;
        code_d    = code_q;
        vote_d    = vote_q;
        ones_d    = ones_q;
        trim_d    = trim_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ones_next = ones_q + VOTE_W'(cal_bit[ch_q]);
        code_res  = vote_ok(int'(ones_next), NVOTE) ? code_q
                                                    : (code_q & ~(TRIM_W'(1) << bit_q));
        unique case (state_q)
            IDLE: begin
                if (trim_wr && (int'(trim_ch) < NCH)) begin
                    trim_d[trim_ch] = trim_wdata;
                end
                if (cal_start) begin
                    state_d = TRIAL;
                    ch_d    = '0;
                    bit_d   = BIT_W'(TRIM_W - 1);
                    code_d  = MID_CODE;
                    vote_d  = '0;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            TRIAL: begin
                if (vote_q == VOTE_W'(NVOTE - 1)) begin
                    vote_d = '0;
                    ones_d = '0;
                    if (bit_q == '0) begin
                        trim_d[ch_q] = code_res;
                        if (ch_q == CH_W'(NCH - 1)) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            ch_d   = ch_q + CH_W'(1);
                            bit_d  = BIT_W'(TRIM_W - 1);
                            code_d = MID_CODE;
                        end
                    end else begin
                        bit_d  = bit_q - BIT_W'(1);
                        code_d = code_res | (TRIM_W'(1) << (bit_q - BIT_W'(1)));
                    end
                end else begin
                    vote_d = vote_q + VOTE_W'(1);
                    ones_d = ones_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ch_q    <= '0;
            bit_q   <= '0;
            code_q  <= '0;
            vote_q  <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                trim_q[i] <= MID_CODE;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            code_q  <= code_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            trim_q  <= trim_d;
        end
    end

    assign trim_rdata = (int'(trim_ch) < NCH) ? trim_q[trim_ch] : '0;
    assign cal_busy   = busy_q;
    assign cal_done   = done_q;

endmodule

// File: tb/tb_comparator_cal_array.sv
// Self-checking bench for comparator_cal_array: randomized stimulus, a behavioural
// reference model, and a scoreboard queue drained by an independent monitor.
module tb_comparator_cal_array;

   localparam int NCH        = 3;
   localparam int TRIM_W     = 6;
   localparam int NVOTE      = 3;
   localparam int LSB_UV     = 1000;
   localparam int HALF_HYST  = 2000;
   localparam int MID        = 32;
   localparam int CAL_CYCLES = NCH * TRIM_W * NVOTE;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [31:0]          vdd;
   logic [NCH*32-1:0]    inp;
   logic [NCH*32-1:0]    inn;
   logic                 cal_start;
   logic                 trim_wr;
   logic [1:0]           trim_ch;
   logic [TRIM_W-1:0]    trim_wdata;
   logic [TRIM_W-1:0]    trim_rdata;
   logic [NCH-1:0]       out;
   logic                 cal_busy;
   logic                 cal_done;

   // One expected DUT state per clock edge, produced by the model when stimulus is issued.
   typedef struct {
      logic [NCH-1:0]    outBits;
      logic              busy;
      logic              done;
      logic [TRIM_W-1:0] rdata;
      bit                checkRdata;
      string             tag;
   } expect_t;

   expect_t expQ[$];
   int      testsRun = 0;
   int      testsFailed = 0;

   // Reference model state: behaviour of the array seen from its pins.
   int diffUv[NCH];
   int vddUv = 1200000;
   int modelTrim[NCH];
   bit modelOut[NCH];
   int modelMode = 0;
   int modelLeft = 0;
   bit modelBusy = 0;
   bit modelDone = 0;

   // 10 ns clock.
   always #5 clk = ~clk;

   comparator_cal_array #(
      .NCH(NCH), .TRIM_W(TRIM_W), .LSB(1.0e-3), .NVOTE(NVOTE),
      .HYST(4.0e-3), .OFFSET0(5.0e-3), .OFFSET_STEP(-12.0e-3)
   ) dut (
      .clk(clk), .rstn(rstn), .vdd(vdd), .inp(inp), .inn(inn),
      .cal_start(cal_start), .trim_wr(trim_wr), .trim_ch(trim_ch),
      .trim_wdata(trim_wdata), .trim_rdata(trim_rdata), .out(out),
      .cal_busy(cal_busy), .cal_done(cal_done)
   );

   // Intrinsic offset of each channel in microvolts.
   function automatic int offsetUv(input int c);
      return 5000 - 12000 * c;
   endfunction

   // Calibration target: the largest code that still leaves a non-negative residual.
   function automatic int idealCode(input int c);
      for (int code = (1 << TRIM_W) - 1; code >= 0; code--) begin
         if (offsetUv(c) - (code - MID) * LSB_UV >= 0) return code;
      end
      return 0;
   endfunction

   // Advances the model by one clock edge given the pin values just driven.
   function automatic void modelStep(input bit rstnVal, input bit startVal, input bit wrVal,
                                     input int chVal, input int wdataVal);
      int d;
      if (!rstnVal) begin
         for (int c = 0; c < NCH; c++) begin
            modelTrim[c] = MID;
            modelOut[c] = 1'b0;
         end
         modelMode = 0;
         modelLeft = 0;
         modelBusy = 1'b0;
         modelDone = 1'b0;
      end else if (modelMode == 0) begin
         for (int c = 0; c < NCH; c++) begin
            d = diffUv[c] + offsetUv(c) - (modelTrim[c] - MID) * LSB_UV;
            if (vddUv < 500000) modelOut[c] = 1'b0;
            else if (modelOut[c]) modelOut[c] = (d >= -HALF_HYST);
            else modelOut[c] = (d >= HALF_HYST);
         end
         if (wrVal && chVal < NCH) modelTrim[chVal] = wdataVal;
         if (startVal) begin
            modelMode = 1;
            modelLeft = CAL_CYCLES;
            modelBusy = 1'b1;
         end
         modelDone = 1'b0;
      end else if (modelMode == 1) begin
         for (int c = 0; c < NCH; c++) modelOut[c] = 1'b0;
         modelLeft--;
         if (modelLeft == 0) begin
            for (int c = 0; c < NCH; c++) modelTrim[c] = idealCode(c);
            modelMode = 2;
            modelBusy = 1'b0;
            modelDone = 1'b1;
         end
      end else begin
         for (int c = 0; c < NCH; c++) modelOut[c] = 1'b0;
         modelDone = 1'b0;
         modelMode = 0;
      end
   endfunction

   // Drives one cycle of pins on the falling edge and queues the expected result.
   task automatic applyStimulus(input bit rstnVal, input bit startVal, input bit wrVal,
                                input int chVal, input int wdataVal, input string tag);
      expect_t e;
      int common;
      @(negedge clk);
      rstn       = rstnVal;
      cal_start  = startVal;
      trim_wr    = wrVal;
      trim_ch    = 2'(chVal);
      trim_wdata = TRIM_W'(wdataVal);
      vdd        = 32'(vddUv);
      for (int c = 0; c < NCH; c++) begin
         common = 400000 + int'($urandom_range(0, 400000));
         inn[c*32 +: 32] = 32'(common);
         inp[c*32 +: 32] = 32'(common + diffUv[c]);
      end
      modelStep(rstnVal, startVal, wrVal, chVal, wdataVal);
      for (int c = 0; c < NCH; c++) e.outBits[c] = modelOut[c];
      e.busy       = modelBusy;
      e.done       = modelDone;
      e.rdata      = (chVal < NCH) ? TRIM_W'(modelTrim[chVal]) : '0;
      e.checkRdata = (modelMode != 1);
      e.tag        = tag;
      expQ.push_back(e);
   endtask

   // Compares one queued expectation against the DUT pins.
   task automatic checkOutput(input expect_t e);
      testsRun++;
      if (out !== e.outBits) begin
         testsFailed++;
         $display("[TB] FAIL %s out: got %b expected %b", e.tag, out, e.outBits);
      end
      testsRun++;
      if (cal_busy !== e.busy) begin
         testsFailed++;
         $display("[TB] FAIL %s cal_busy: got %b expected %b", e.tag, cal_busy, e.busy);
      end
      testsRun++;
      if (cal_done !== e.done) begin
         testsFailed++;
         $display("[TB] FAIL %s cal_done: got %b expected %b", e.tag, cal_done, e.done);
      end
      if (e.checkRdata) begin
         testsRun++;
         if (trim_rdata !== e.rdata) begin
            testsFailed++;
            $display("[TB] FAIL %s trim_rdata(ch %0d): got %0d expected %0d",
                     e.tag, trim_ch, trim_rdata, e.rdata);
         end
      end
   endtask

   // Monitor: one sample per clock, 1 ns after the rising edge.
   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   // Safety net so the run can never hang.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Stimulus sequence.
   initial begin
      rstn = 1'b0; cal_start = 1'b0; trim_wr = 1'b0; trim_ch = '0; trim_wdata = '0;
      vdd = 32'(vddUv); inp = '0; inn = '0;
      for (int c = 0; c < NCH; c++) diffUv[c] = 0;

      // Reset with readback of every channel.
      for (int c = 0; c < NCH; c++) applyStimulus(1'b0, 1'b0, 1'b0, c, 0, "reset");

      // Coarse ramp up then down on all channels at the reset trim.
      for (int v = -10000; v <= 10000; v += 1000) begin
         for (int c = 0; c < NCH; c++) diffUv[c] = v;
         applyStimulus(1'b1, 1'b0, 1'b0, (v / 1000 + 10) % NCH, 0, "ramp_up");
      end
      for (int v = 10000; v >= -10000; v -= 1000) begin
         for (int c = 0; c < NCH; c++) diffUv[c] = v;
         applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, "ramp_down");
      end

      // Fine sweep through the hysteresis window of channel 0 (edges at -3 mV and -7 mV).
      for (int v = -10000; v <= 0; v += 500) begin
         diffUv[0] = v;
         applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, "hyst_up");
      end
      for (int v = 0; v >= -10000; v -= 500) begin
         diffUv[0] = v;
         applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, "hyst_down");
      end

      // Random normal operation with supply dips and trim writes (channel 3 is out of range).
      for (int i = 0; i < 150; i++) begin
         int pick;
         for (int c = 0; c < NCH; c++) diffUv[c] = int'($urandom_range(0, 30000)) - 15000;
         pick = int'($urandom_range(0, 9));
         vddUv = (pick == 0) ? 300000 : (pick == 1) ? 499999 : (pick == 2) ? 500000 : 1200000;
         applyStimulus(1'b1, 1'b0, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 63)), "random");
      end
      vddUv = 1200000;

      // Calibration launched together with a trim write, then hammered with ignored requests.
      applyStimulus(1'b1, 1'b1, 1'b1, 0, 5, "cal_start");
      for (int i = 0; i < CAL_CYCLES + 1; i++) begin
         for (int c = 0; c < NCH; c++) diffUv[c] = int'($urandom_range(0, 30000)) - 15000;
         applyStimulus(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), "cal_busy");
      end
      for (int c = 0; c <= NCH; c++) applyStimulus(1'b1, 1'b0, 1'b0, c, 0, "cal_result");

      // Residual threshold after calibration sits within one LSB of zero on every channel.
      for (int v = -3000; v <= 3000; v += 250) begin
         for (int c = 0; c < NCH; c++) diffUv[c] = v;
         applyStimulus(1'b1, 1'b0, 1'b0, (v / 250 + 12) % NCH, 0, "post_cal_up");
      end
      for (int v = 3000; v >= -3000; v -= 250) begin
         for (int c = 0; c < NCH; c++) diffUv[c] = v;
         applyStimulus(1'b1, 1'b0, 1'b0, 1, 0, "post_cal_down");
      end

      // Reset ten cycles into a calibration aborts it and restores the mid-scale trims.
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, "abort_start");
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, "abort_run");
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, "abort_reset");
      for (int c = 0; c < NCH; c++) applyStimulus(1'b1, 1'b0, 1'b0, c, 0, "abort_after");

      // A full calibration with quiet pins for a clean result.
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, "cal2_start");
      for (int i = 0; i < CAL_CYCLES + 1; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2, 0, "cal2_run");
      for (int c = 0; c < NCH; c++) applyStimulus(1'b1, 1'b0, 1'b0, c, 0, "cal2_result");

      // Drain the scoreboard within a bounded number of cycles.
      repeat (4) @(posedge clk);
      #2;
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/comparator_cal_array.md
# comparator_cal_array

Multi-channel clocked comparator array with per-channel digital offset trim and an on-chip SAR offset-calibration engine. It is the parametrised successor of the single continuous-time comparator with fixed 5-bit p/n offset codes. It generalises that block to NCH channels, a signed trim of TRIM_W bits, optional hysteresis, and automatic calibration with majority voting. It sits between the PWL analog front end and digital receive logic, and produces one registered decision per channel per clock.

## Interface
- NCH, 4: number of comparator channels (≥1).
- TRIM_W, 6: trim code width (offset-binary, ≥2).
- LSB, 1.0e-3: trim step in volts (real).
- NVOTE, 3: samples per SAR trial (odd, ≥1).
- HYST, 0.0: total hysteresis window in volts (real, ≥0).
- OFFSET0, 0.0: intrinsic input offset of channel 0, in volts (real).
- OFFSET_STEP, 0.0: intrinsic offset increment per channel index, in volts (real).
- clk  input  1  sampling/control clock.
- rstn  input  1  synchronous, active-low reset (sampled on posedge clk).
- vdd  input_pwl  1  supply; decisions are forced to 0 when vdd < 0.5 V.
- inp[NCH], inn[NCH]  input_pwl  NCH  differential inputs.
- cal_start  input  1  one-cycle pulse that starts calibration of all channels.
- trim_wr  input  1  write strobe for the trim register.
- trim_ch  input  max(1,$clog2(NCH))  channel select for trim write/readback.
- trim_wdata  input  TRIM_W  trim write data.
- trim_rdata  output  TRIM_W  trim of channel trim_ch (combinational readback).
- out  output  NCH  registered decisions.
- cal_busy  output  1  calibration in progress.
- cal_done  output  1  one-cycle pulse when calibration completes.

## Operation
- Effective threshold for channel c: off_c = OFFSET0 + c·OFFSET_STEP; trim_v_c = (trim_c − 2^(TRIM_W−1))·LSB.
- Normal mode (IDLE): on each posedge, for each c, d = pm.eval(inp[c]) − pm.eval(inn[c]) + off_c − trim_v_c, evaluated at the edge time.
  - If out[c] = 0: out[c] ← (d ≥ +HYST/2).
  - If out[c] = 1: out[c] ← (d ≥ −HYST/2).
- Trim write: when trim_wr = 1 in IDLE, trim[trim_ch] ← trim_wdata. The write is ignored while cal_busy = 1 and ignored when trim_ch ≥ NCH.
- FSM states are IDLE, TRIAL and DONE.
  - IDLE → TRIAL on cal_start. Setup: ch = 0, bit = TRIM_W−1, trial code = 1 at bit, 0 below. All out bits are held at 0.
  - TRIAL: the channel input is internally shorted, so d = off_ch − trim_v_ch with the trial code applied and no hysteresis.
    - Sample NVOTE cycles and count ones.
    - Majority result = (2·ones ≥ NVOTE). Result 1 keeps the bit; result 0 clears it.
    - Then set the next lower bit. After bit 0, latch the code into trim[ch] and move to ch+1, bit TRIM_W−1.
  - After the last channel, TRIAL → DONE.
  - DONE → IDLE after one cycle; cal_done = 1 during DONE.
- Result: calibration leaves the largest code with off_c − trim_v_c ≥ 0, clamped to 0..2^TRIM_W−1.
- cal_start while busy or in DONE is ignored.
- A trim_wr in the same cycle as cal_start: the write is applied first, then calibration overwrites it.

## Timing
- Reset values (rstn = 0 at posedge): out = 0, cal_busy = 0, cal_done = 0, FSM = IDLE, every trim = 2^(TRIM_W−1) (zero correction), vote counter = 0.
- Reset mid-calibration aborts immediately. Trims return to the reset value, with no partial codes kept.
- Normal decision latency: one clock (input at posedge k → out at posedge k).
- cal_busy rises the cycle after cal_start and stays high for exactly NCH·TRIM_W·NVOTE cycles.
- cal_done pulses in the following cycle, with cal_busy = 0.
- out resumes normal sampling on the first posedge after DONE. Hysteresis state starts from out = 0.
- trim_rdata follows trim_ch combinationally. It reflects a write from the next cycle.

## Structure
- Package comparator_cal_pkg holds:
  - the FSM state enum (IDLE/TRIAL/DONE);
  - the function trim_to_volts(code, LSB, TRIM_W);
  - the majority function vote_ok(ones, NVOTE).
- Sub-module comparator_slice (one per channel, generate loop): PWL evaluation, trim subtraction, hysteresis, and the out register.
- The top level holds the shared SAR FSM, the vote counter and the trim register file.

## Test plan
- Reset: rstn = 0 for 2 cycles → out = 0, cal_busy = 0, trim_rdata = 32 (TRIM_W = 6) for every channel.
- Normal compare: NCH = 2, offsets 0, inp − inn ramps −10 mV → +10 mV → out[0] toggles on the first posedge with d ≥ 0; one-cycle latency checked.
- Hysteresis: HYST = 4 mV, input swept up then down → rise at +2 mV, fall at −2 mV, no toggling for inputs between them.
- Calibration: NCH = 2, TRIM_W = 6, NVOTE = 3, OFFSET0 = 5 mV, OFFSET_STEP = −12 mV, cal_start pulse.
  - cal_busy is high for 36 cycles, then cal_done pulses.
  - Final trims: ch0 = 37, ch1 = 25.
  - Post-calibration threshold is within 1 LSB of zero.
- Clamp: OFFSET0 = +50 mV, TRIM_W = 6 → ch0 trim = 63; OFFSET0 = −50 mV → ch0 trim = 0.
- Interference cases:
  - rstn = 0 at cycle 10 of calibration → trims return to 32, no cal_done.
  - cal_start and trim_wr issued while busy → both ignored, and calibration results are unchanged.
